// File: rtl/j2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : j2_pkg
// Description : Shared constants for the j2 core stacks: encodings of the
//               signed pointer delta supplied by the ALU, default cell width
//               and pointer width, and a helper that turns a delta into the
//               number of entries it removes.
// Revision    : 1.0 - initial release
// ============================================================================
package j2_pkg;

  // Pointer delta encodings (2-bit two's complement)
  localparam logic [1:0] DELTA_HOLD = 2'b00;  //  0
  localparam logic [1:0] DELTA_PUSH = 2'b01;  // +1
  localparam logic [1:0] DELTA_POP1 = 2'b11;  // -1
  localparam logic [1:0] DELTA_POP2 = 2'b10;  // -2

  // Defaults used by the core when instantiating its stacks
  localparam int J2_WIDTH = 16;
  localparam int J2_DEPTH = 4;

  // Number of entries a delta pops (0 for hold and push).
  function automatic logic [1:0] pop_amount(input logic [1:0] delta);
    logic [1:0] amount;
    amount = 2'd0;
    if (delta == DELTA_POP1) amount = 2'd1;
    else if (delta == DELTA_POP2) amount = 2'd2;
    return amount;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stack_ram.sv
`default_nettype none
// ============================================================================
// Module      : stack_ram
// Description : 2**DEPTH x WIDTH storage for the entries below T.
//               Asynchronous read, single synchronous write port, no reset.
// Ports       : clock        - rising-edge clock
//               write_enable - write write_data to write_addr on this edge
//               write_addr   - write address
//               write_data   - write data
//               read_addr    - read address
//               read_data    - combinational read data
// Revision    : 1.0 - initial release
// ============================================================================
module stack_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             write_enable,
  input  logic [DEPTH-1:0] write_addr,
  input  logic [WIDTH-1:0] write_data,
  input  logic [DEPTH-1:0] read_addr,
  output logic [WIDTH-1:0] read_data
);

  localparam int ENTRIES = 2 ** DEPTH;

  logic [WIDTH-1:0] mem_q [ENTRIES];

  always_ff @(posedge clock) begin
    if (write_enable) begin
      mem_q[write_addr] <= write_data;
    end
  end

  assign read_data = mem_q[read_addr];

endmodule
`default_nettype wire

// File: rtl/stack_unit.sv
`default_nettype none
// ============================================================================
// Module      : stack_unit
// Description : Data/return stack for the j2 core. T lives in a register,
//               the entries below it live in stack_ram addressed by a
//               wrapping pointer sp. Each enabled cycle applies a signed
//               pointer delta and loads a new T. Occupancy is tracked in
//               count (0..2**DEPTH).
// Config      : STACK_GUARD_EN - when defined, pushes into a full stack and
//               pops deeper than the occupancy are blocked and latch sticky
//               overflow/underflow flags. When undefined nothing is blocked,
//               sp wraps, count saturates and both flags read 0.
// Ports       : clock            - rising-edge clock
//               active_low_reset - asynchronous active-low reset
//               enable           - apply delta/top_in this cycle
//               delta            - pointer move (hold/+1/-1/-2)
//               top_in           - new T value
//               clear_errors     - clears sticky flags (set wins)
//               top              - registered T
//               next             - N = mem[sp], 0 when the stack is empty
//               depth_count      - entries held below T
//               overflow         - sticky push-while-full flag
//               underflow        - sticky pop-too-deep flag
// Revision    : 1.0 - initial release
// ============================================================================
module stack_unit
  import j2_pkg::*;
#(
  parameter int WIDTH = J2_WIDTH,
  parameter int DEPTH = J2_DEPTH
) (
  input  logic             clock,
  input  logic             active_low_reset,
  input  logic             enable,
  input  logic [1:0]       delta,
  input  logic [WIDTH-1:0] top_in,
  input  logic             clear_errors,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] next,
  output logic [DEPTH:0]   depth_count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [DEPTH:0] FULL_COUNT = {1'b1, {DEPTH{1'b0}}};

  logic [WIDTH-1:0] top_q, top_d;
  logic [DEPTH-1:0] sp_q, sp_d;
  logic [DEPTH:0]   count_q, count_d;

  logic [1:0]       pop_amt;
  logic [DEPTH:0]   pop_amt_count;
  logic [DEPTH-1:0] pop_amt_sp;
  logic             is_push;
  logic             is_pop;
  logic             push_blocked;
  logic             pop_blocked;

  logic             ram_write_enable;
  logic [DEPTH-1:0] ram_write_addr;
  logic [WIDTH-1:0] ram_read_data;

  assign pop_amt       = pop_amount(delta);
  assign pop_amt_count = (DEPTH+1)'(pop_amt);
  assign pop_amt_sp    = DEPTH'(pop_amt);
  assign is_push       = (delta == DELTA_PUSH);
  assign is_pop        = (pop_amt != 2'd0);

`ifdef STACK_GUARD_EN
  assign push_blocked = is_push && (count_q == FULL_COUNT);
  assign pop_blocked  = is_pop && (count_q < pop_amt_count);
`else
  assign push_blocked = 1'b0;
  assign pop_blocked  = 1'b0;
`endif

  // Next-state for T, pointer and occupancy. A blocked op behaves as a stall.
  always_comb begin
    top_d            = top_q;
    sp_d             = sp_q;
    count_d          = count_q;
    ram_write_enable = 1'b0;
    ram_write_addr   = sp_q + DEPTH'(1);
    if (enable && !push_blocked && !pop_blocked) begin
      top_d = top_in;
      if (is_push) begin
        // Old T spills into the slot just above the current N.
        ram_write_enable = 1'b1;
        sp_d             = sp_q + DEPTH'(1);
        count_d          = (count_q == FULL_COUNT) ? count_q : count_q + (DEPTH+1)'(1);
      end else if (is_pop) begin
        sp_d    = sp_q - pop_amt_sp;
        count_d = (count_q < pop_amt_count) ? '0 : count_q - pop_amt_count;
      end
    end
  end

  always_ff @(posedge clock or negedge active_low_reset) begin
    if (!active_low_reset) begin
      top_q   <= '0;
      sp_q    <= '0;
      count_q <= '0;
    end else begin
      top_q   <= top_d;
      sp_q    <= sp_d;
      count_q <= count_d;
    end
  end

`ifdef STACK_GUARD_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Clear first, then any detection this cycle overrides it (set wins).
  always_comb begin
    overflow_d  = clear_errors ? 1'b0 : overflow_q;
    underflow_d = clear_errors ? 1'b0 : underflow_q;
    if (enable && push_blocked) overflow_d = 1'b1;
    if (enable && pop_blocked) underflow_d = 1'b1;
  end

  always_ff @(posedge clock or negedge active_low_reset) begin
    if (!active_low_reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  logic unused_clear_errors;
  assign unused_clear_errors = clear_errors;
  assign overflow            = 1'b0;
  assign underflow           = 1'b0;
`endif

  stack_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_stack_ram (
    .clock        (clock),
    .write_enable (ram_write_enable),
    .write_addr   (ram_write_addr),
    .write_data   (top_q),
    .read_addr    (sp_q),
    .read_data    (ram_read_data)
  );

  assign top         = top_q;
  assign depth_count = count_q;
  // Memory is not reset, so an empty stack must mask whatever sits at sp.
  assign next        = (count_q == '0) ? '0 : ram_read_data;

endmodule
`default_nettype wire

// File: tb/tb_stack_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_stack_unit
// Description : Self-checking bench for stack_unit (WIDTH=16, DEPTH=2).
//               A table of directed vectors covers push/pop/hold/stall;
//               hand-written sequences cover overflow, underflow, flag
//               clearing (guard build), wrap/saturation (unguarded build)
//               and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stack_unit;
  import j2_pkg::*;

  localparam int WIDTH = 16;
  localparam int DEPTH = 2;

  logic             clock;
  logic             active_low_reset;
  logic             enable;
  logic [1:0]       delta;
  logic [WIDTH-1:0] top_in;
  logic             clear_errors;
  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] next;
  logic [DEPTH:0]   depth_count;
  logic             overflow;
  logic             underflow;

  int errors = 0;
  int checks = 0;

  stack_unit #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clock            (clock),
    .active_low_reset (active_low_reset),
    .enable           (enable),
    .delta            (delta),
    .top_in           (top_in),
    .clear_errors     (clear_errors),
    .top              (top),
    .next             (next),
    .depth_count      (depth_count),
    .overflow         (overflow),
    .underflow        (underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        en;
    logic [1:0]  d;
    logic [15:0] ti;
    logic        clr;
    logic [15:0] e_top;
    logic [15:0] e_next;
    logic [2:0]  e_count;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [15:0] e_top, input logic [15:0] e_next,
                             input logic [2:0] e_count, input logic e_ovf, input logic e_unf);
    check({tag, ".top"},       32'(top),         32'(e_top));
    check({tag, ".next"},      32'(next),        32'(e_next));
    check({tag, ".count"},     32'(depth_count), 32'(e_count));
    check({tag, ".overflow"},  32'(overflow),    32'(e_ovf));
    check({tag, ".underflow"}, 32'(underflow),   32'(e_unf));
  endtask

  // Drive inputs, take one rising edge, sample 1 ns later.
  task automatic step(input logic en, input logic [1:0] d, input logic [15:0] ti, input logic clr);
    enable       = en;
    delta        = d;
    top_in       = ti;
    clear_errors = clr;
    @(posedge clock);
    #1;
  endtask

  // Assert reset between edges, check it took effect immediately, release.
  task automatic mid_reset(input string tag);
    enable       = 1'b1;
    delta        = DELTA_PUSH;
    top_in       = 16'hFFFF;
    clear_errors = 1'b0;
    @(negedge clock);
    #2;
    active_low_reset = 1'b0;
    #1;
    check_state(tag, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0);
    enable = 1'b0;
    @(negedge clock);
    active_low_reset = 1'b1;
    @(posedge clock);
    #1;
    check_state({tag, "_rel"}, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0);
  endtask

  initial begin
    vecs[0]  = '{1'b1, DELTA_PUSH, 16'h1111, 1'b0, 16'h1111, 16'h0000, 3'd1};
    vecs[1]  = '{1'b1, DELTA_PUSH, 16'h2222, 1'b0, 16'h2222, 16'h1111, 3'd2};
    vecs[2]  = '{1'b1, DELTA_PUSH, 16'h3333, 1'b0, 16'h3333, 16'h2222, 3'd3};
    vecs[3]  = '{1'b1, DELTA_POP1, 16'h5555, 1'b0, 16'h5555, 16'h1111, 3'd2};
    vecs[4]  = '{1'b1, DELTA_POP2, 16'hAAAA, 1'b0, 16'hAAAA, 16'h0000, 3'd0};
    vecs[5]  = '{1'b1, DELTA_HOLD, 16'h1234, 1'b0, 16'h1234, 16'h0000, 3'd0};
    vecs[6]  = '{1'b0, DELTA_PUSH, 16'h7777, 1'b0, 16'h1234, 16'h0000, 3'd0};
    vecs[7]  = '{1'b0, DELTA_PUSH, 16'h7777, 1'b0, 16'h1234, 16'h0000, 3'd0};
    vecs[8]  = '{1'b0, DELTA_PUSH, 16'h7777, 1'b0, 16'h1234, 16'h0000, 3'd0};
    vecs[9]  = '{1'b1, DELTA_PUSH, 16'hBBBB, 1'b0, 16'hBBBB, 16'h1234, 3'd1};
    vecs[10] = '{1'b1, DELTA_HOLD, 16'hCCCC, 1'b0, 16'hCCCC, 16'h1234, 3'd1};

    active_low_reset = 1'b0;
    enable           = 1'b0;
    delta            = DELTA_HOLD;
    top_in           = '0;
    clear_errors     = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_state("reset", 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0);
    @(negedge clock);
    active_low_reset = 1'b1;

    for (int i = 0; i < 11; i++) begin
      step(vecs[i].en, vecs[i].d, vecs[i].ti, vecs[i].clr);
      check_state($sformatf("vec%0d", i), vecs[i].e_top, vecs[i].e_next, vecs[i].e_count, 1'b0, 1'b0);
    end

`ifdef STACK_GUARD_EN
    // count = 1, pop of two is blocked
    step(1'b1, DELTA_POP2, 16'hDDDD, 1'b0);
    check_state("underflow", 16'hCCCC, 16'h1234, 3'd1, 1'b0, 1'b1);
    step(1'b0, DELTA_HOLD, 16'h0000, 1'b1);
    check_state("unf_clear", 16'hCCCC, 16'h1234, 3'd1, 1'b0, 1'b0);

    // fill to 4 entries
    step(1'b1, DELTA_PUSH, 16'h0001, 1'b0);
    check_state("fill1", 16'h0001, 16'hCCCC, 3'd2, 1'b0, 1'b0);
    step(1'b1, DELTA_PUSH, 16'h0002, 1'b0);
    step(1'b1, DELTA_PUSH, 16'h0003, 1'b0);
    check_state("full", 16'h0003, 16'h0002, 3'd4, 1'b0, 1'b0);

    step(1'b1, DELTA_PUSH, 16'h9999, 1'b0);
    check_state("overflow", 16'h0003, 16'h0002, 3'd4, 1'b1, 1'b0);
    step(1'b0, DELTA_HOLD, 16'h0000, 1'b1);
    check_state("ovf_clear", 16'h0003, 16'h0002, 3'd4, 1'b0, 1'b0);
    step(1'b1, DELTA_PUSH, 16'h9999, 1'b1);
    check_state("ovf_set_wins", 16'h0003, 16'h0002, 3'd4, 1'b1, 1'b0);
    step(1'b0, DELTA_PUSH, 16'h9999, 1'b0);
    check_state("ovf_sticky", 16'h0003, 16'h0002, 3'd4, 1'b1, 1'b0);

    mid_reset("mid_reset");
`else
    mid_reset("mid_reset");

    // six pushes into a 4-entry stack: count saturates, oldest overwritten
    for (int k = 1; k <= 6; k++) begin
      step(1'b1, DELTA_PUSH, 16'h1000 + 16'(k), 1'b1);
    end
    check_state("wrap6", 16'h1006, 16'h1005, 3'd4, 1'b0, 1'b0);

    // pop below empty saturates count at 0
    step(1'b1, DELTA_POP2, 16'h2000, 1'b0);
    check_state("pop2", 16'h2000, 16'h1003, 3'd2, 1'b0, 1'b0);
    step(1'b1, DELTA_POP1, 16'h2001, 1'b0);
    step(1'b1, DELTA_POP2, 16'h2002, 1'b0);
    check_state("pop_sat", 16'h2002, 16'h0000, 3'd0, 1'b0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stack_unit.md
# stack_unit

Parametrised data/return stack for the j2 core. The top of stack (T) is held in a register, and the remaining entries sit in a small register file addressed by a wrapping pointer. Each enabled cycle, the core's ALU supplies a signed pointer delta and a new T. The unit tracks occupancy and, when the guard is compiled in, detects and blocks overflow and underflow with sticky error flags. One instance serves as the data stack and a second as the return stack.

## Interface
- WIDTH, 16, cell width in bits
- DEPTH, 4, pointer width; the register file holds 2**DEPTH entries below T
- clock  in  1  rising-edge clock
- active_low_reset  in  1  asynchronous, active-low reset
- enable  in  1  apply delta/top_in this cycle; 0 = stall
- delta  in  2  signed pointer move: 2'b00 hold, 2'b01 +1 (push), 2'b11 -1 (pop), 2'b10 -2
- top_in  in  WIDTH  new T value, loaded on every enabled, non-blocked cycle
- clear_errors  in  1  clears the sticky overflow/underflow flags
- top  out  WIDTH  registered T
- next  out  WIDTH  second element (N) = mem[sp]; 0 when depth_count == 0
- depth_count  out  DEPTH+1  entries held below T, range 0..2**DEPTH
- overflow  out  1  sticky: a push was attempted while full
- underflow  out  1  sticky: a pop was attempted with depth_count < |delta|

## Operation
- State: T register, sp (DEPTH bits), count (DEPTH+1 bits), memory, two sticky flags.
- Push (+1): mem[sp+1] <= T; sp <= sp+1; count <= count+1; T <= top_in.
- Hold (0): sp, count and memory unchanged; T <= top_in.
- Pop (-1/-2): sp <= sp-|delta|; count <= count-|delta|; memory unchanged; T <= top_in.
- All sp arithmetic is modulo 2**DEPTH. count never wraps in either build.
- Blocked op (guard build only): push with count == 2**DEPTH, or pop with count < |delta|.
  - A blocked op leaves T, sp, count and memory unchanged.
  - It sets overflow or underflow respectively.
- enable = 0: T, sp, count and memory hold; no error detection.
- clear_errors acts regardless of enable. If an error is detected in the same cycle as clear_errors, the flag ends at 1 (set wins).
- No FSM beyond the occupancy counter. T and N are read combinationally, so an ALU operation completes in a single cycle.

## Timing
- Reset (asynchronous, while active_low_reset = 0): T = 0, sp = 0, count = 0, overflow = 0, underflow = 0, so next = 0. Memory contents are not reset.
- All state updates occur on the rising edge of clock when enable = 1 and active_low_reset = 1.
- top, depth_count and the flags are registered outputs and are valid the cycle after the edge.
- next is combinational from sp and count. After a push, next equals the pre-push T in the following cycle (single write port; write-then-read across the edge).
- Reset may be asserted mid-operation; all state listed above returns to its reset value immediately.
- Latency: 1 cycle from inputs to visible stack state. There is no backpressure; enable is the only stall.

## Configuration
- Macro STACK_GUARD_EN.
- Defined: occupancy checks run, blocked ops are suppressed, and overflow/underflow are sticky as described above.
- Undefined: no ops are blocked. sp wraps, and a push when full overwrites the oldest entry. count saturates at 2**DEPTH on push and at 0 on pop. overflow and underflow are constant 0, and clear_errors is ignored.

## Structure
- Shared package j2_pkg holds:
  - localparams DELTA_HOLD, DELTA_PUSH, DELTA_POP1, DELTA_POP2;
  - the default WIDTH/DEPTH constants used by the core.
- Sub-module stack_ram: 2**DEPTH x WIDTH, asynchronous read, synchronous single write port, no reset. stack_unit owns the pointer, T, count and flag logic.

## Test plan
Benches run with WIDTH = 16, DEPTH = 2 (4 entries); the guard build is the default.
- Reset: assert active_low_reset mid-stream -> top = 0, next = 0, depth_count = 0, both flags 0.
- Push 0x1111, 0x2222, 0x3333 on consecutive enabled cycles (delta = +1) -> top = 0x3333, next = 0x2222, depth_count = 3.
- From that state:
  - delta = -1, top_in = 0x5555 -> top = 0x5555, next = 0x1111, depth_count = 2;
  - then delta = -2, top_in = 0xAAAA -> top = 0xAAAA, depth_count = 0, next = 0.
- Overflow (guard), reached by pushing until depth_count = 4:
  - one more push with top_in = 0x9999 -> overflow = 1, top and depth_count unchanged;
  - clear_errors pulse -> overflow = 0;
  - clear_errors coincident with another blocked push -> overflow stays 1.
- Underflow (guard): with depth_count = 1, apply delta = -2 -> underflow = 1, top, next and depth_count unchanged.
- enable = 0 with delta = +1 for 3 cycles -> no change.
- Build without STACK_GUARD_EN, then apply 6 pushes -> depth_count = 4, next = the 5th pushed T, flags 0.
